i2s_slave_xcvr: RTL and testbench

//  Codec-side (slave) I2S transceiver. Follows SCLK/LRCLK driven by the Equalizer's codec master.

---
 rtl/i2s_slave_xcvr.sv | 108 ++++++++++
 tb/tb_i2s_slave_xcvr.sv | 134 +++++++++++++
 2 files changed

// File: rtl/i2s_slave_xcvr.sv
// i2s_slave_xcvr: codec-side I2S slave transceiver, follows master SCLK/LRCLK, oversampled on clk
//   clk, RST_n               system clock, asynchronous active-low reset
//   SCLK, LRCLK, SDin        bit clock, word select (0=left, 1=right) and serial data from the master
//   SDout                    serial data to the master, MSB one SCLK after each LRCLK edge
//   tx_lft, tx_rht, tx_ack   words to send; captured for the new frame on the tx_ack pulse
//   rx_lft, rx_rht, rx_vld   last clean received frame; updated on the rx_vld pulse
//   frm_err                  pulse when an LRCLK edge ends a half-frame of the wrong length
module i2s_slave_xcvr #(
  parameter int DW         = 24,
  parameter int FRAME_BITS = 32
) (
  input  logic          clk,
  input  logic          RST_n,
  input  logic          SCLK,
  input  logic          LRCLK,
  input  logic          SDin,
  output logic          SDout,
  input  logic [DW-1:0] tx_lft,
  input  logic [DW-1:0] tx_rht,
  output logic          tx_ack,
  output logic [DW-1:0] rx_lft,
  output logic [DW-1:0] rx_rht,
  output logic          rx_vld,
  output logic          frm_err
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int BW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  state_t state, state_nx;
  logic [2:0] sclk_s, lr_s;
  logic [1:0] sd_s;
  logic [CW-1:0] bit_cnt;
  logic [BW-1:0] bidx;
  logic [DW-1:0] sh_l, sh_r, sr_l, sr_r, hold_l, tx_word;
  logic sclk_rise, sclk_fall, lr_rise, lr_fall, lr_edge;
  logic in_frame, cnt_full, in_rng, cap, pend, dirty;
  // stage 2 vs stage 3 of each synchronizer gives the edge strobes
  always_comb begin
    sclk_rise = sclk_s[1] & ~sclk_s[2];
    sclk_fall = ~sclk_s[1] & sclk_s[2];
    lr_rise   = lr_s[1] & ~lr_s[2];
    lr_fall   = ~lr_s[1] & lr_s[2];
    lr_edge   = lr_rise | lr_fall;
    in_frame  = state != IDLE;
    cnt_full  = bit_cnt == CW'(FRAME_BITS);
    in_rng    = bit_cnt != '0 && bit_cnt <= CW'(DW);
    bidx      = BW'(DW - int'(bit_cnt));
    tx_word   = state == RIGHT ? sh_r : sh_l;
    cap       = in_frame && sclk_rise && !lr_edge && in_rng;
    state_nx  = lr_fall ? LEFT : (lr_rise && in_frame) ? RIGHT : state;
  end
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) begin
      sclk_s <= '0;
      lr_s   <= '0;
      sd_s   <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], SCLK};
      lr_s   <= {lr_s[1:0], LRCLK};
      sd_s   <= {sd_s[0], SDin};
    end
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) begin
      bit_cnt <= '0;
      SDout   <= 1'b0;
      tx_ack  <= 1'b0;
      rx_vld  <= 1'b0;
      frm_err <= 1'b0;
      rx_lft  <= '0;
      rx_rht  <= '0;
      sh_l    <= '0;
      sh_r    <= '0;
      sr_l    <= '0;
      sr_r    <= '0;
      hold_l  <= '0;
      pend    <= 1'b0;
      dirty   <= 1'b0;
    end else begin
      tx_ack  <= lr_fall;
      frm_err <= lr_edge && in_frame && !cnt_full;
      rx_vld  <= pend && !dirty;
      pend    <= cap && state == RIGHT && bit_cnt == CW'(DW);
      if (pend && !dirty) begin
        rx_lft <= hold_l;
        rx_rht <= sr_r;
      end
      // a bad edge taints the frame it opens; a clean lr_fall starts a fresh frame
      if (lr_fall) begin
        sh_l  <= tx_lft;
        sh_r  <= tx_rht;
        dirty <= in_frame && !cnt_full;
      end
      if (lr_rise && in_frame) begin
        dirty <= dirty | !cnt_full;
        if (cnt_full) hold_l <= sr_l;
      end
      if (lr_edge || !in_frame) bit_cnt <= '0;
      else if (sclk_rise && !cnt_full) bit_cnt <= bit_cnt + 1'b1;
      // edge wins over a coincident fall: the delay slot always carries 0
      if (lr_edge || !in_frame) SDout <= 1'b0;
      else if (sclk_fall) SDout <= in_rng && tx_word[bidx];
      if (cap && state == LEFT) sr_l[bidx] <= sd_s[1];
      if (cap && state == RIGHT) sr_r[bidx] <= sd_s[1];
    end
endmodule

// File: tb/tb_i2s_slave_xcvr.sv
// tb_i2s_slave_xcvr: randomized scoreboard bench with an I2S master model for i2s_slave_xcvr
module tb_i2s_slave_xcvr;
  logic clk = 1'b0;
  logic RST_n, SCLK, LRCLK, SDin, SDout, tx_ack, rx_vld, frm_err;
  logic [23:0] tx_lft, tx_rht, rx_lft, rx_rht;
  int checks = 0, fails = 0, acks = 0, errs = 0, exp_err = 0, nfrm = 0, m_nr = 32;
  bit m_in = 1'b0, ramp = 1'b0;
  logic [47:0] rx_q[$], tx_q[$];
  always #10 clk = ~clk;
  i2s_slave_xcvr #(.DW(24), .FRAME_BITS(32)) dut (
    .clk(clk), .RST_n(RST_n), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin), .SDout(SDout),
    .tx_lft(tx_lft), .tx_rht(tx_rht), .tx_ack(tx_ack),
    .rx_lft(rx_lft), .rx_rht(rx_rht), .rx_vld(rx_vld), .frm_err(frm_err)
  );
  task automatic chk(input string n, input logic [47:0] a, input logic [47:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  // words on the inputs at a tx_ack are what the frame must carry; then load the next ones
  initial forever begin
    @(negedge clk);
    if (tx_ack) begin
      tx_q.push_back({tx_lft, tx_rht});
      tx_lft = ramp ? tx_lft + 24'd1 : 24'($urandom);
      tx_rht = ramp ? tx_rht + 24'd1 : 24'($urandom);
    end
  end
  initial forever begin
    @(negedge clk);
    if (rx_vld) begin
      if (rx_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rx_unexpected got=%h exp=none", {rx_lft, rx_rht});
      end else chk("rx_word", {rx_lft, rx_rht}, rx_q.pop_front());
    end
    if (tx_ack) acks++;
    if (frm_err) errs++;
  end
  // one SCLK period of the master: fall (drive LRCLK/SDin), then rise (sample SDout)
  task automatic bitp(input logic lr, input int i, input logic [23:0] w, inout logic [23:0] d, input bit rst);
    SCLK = 1'b0;
    LRCLK = lr;
    SDin = (i >= 1 && i <= 24) ? w[24-i] : 1'b0;
    if (rst) begin
      #20 RST_n = 1'b0;
      #1 chk("rst_rx", {rx_lft, rx_rht}, 48'd0);
      chk("rst_ctl", {44'd0, SDout, tx_ack, rx_vld, frm_err}, 48'd0);
      m_in = 1'b0;
      #99 RST_n = 1'b1;
      #40;
    end else #160;
    SCLK = 1'b1;
    if (i >= 1 && i <= 24) d[24-i] = SDout;
    #160;
  endtask
  // a frame opens at a LRCLK fall; reference rules: an edge ending a half of length != 32 while
  // synced is a framing error and kills the frame it opens; a frame is received when clean
  task automatic frame(input logic [23:0] l, input logic [23:0] r, input logic [47:0] rexp,
                       input int nr, input int rst_at, output logic [47:0] dec, output logic [47:0] txw);
    logic [23:0] dl, dr;
    logic [47:0] t;
    bit ok;
    dl = '0;
    dr = '0;
    ok = !(m_in && m_nr != 32);
    if (!ok) exp_err++;
    m_in = 1'b1;
    nfrm++;
    for (int i = 0; i < 32; i++) bitp(1'b0, i, l, dl, i == rst_at);
    if (ok && m_in && nr > 24) rx_q.push_back(rexp);
    for (int i = 0; i < nr; i++) bitp(1'b1, i, r, dr, 1'b0);
    m_nr = nr;
    dec = {dl, dr};
    txw = dec;
    if (tx_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL tx_missing got=none exp=word frame=%0d", nfrm);
    end else begin
      t = tx_q.pop_front();
      txw = t;
      if (m_in) chk("tx_word", dec, t);
    end
  endtask
  initial begin
    logic [47:0] dec, txw, prev;
    logic [23:0] a, b, dmy;
    dmy = '0;
    RST_n = 1'b0;
    SCLK = 1'b1;
    LRCLK = 1'b1;
    SDin = 1'b0;
    tx_lft = 24'hA5C3F0;
    tx_rht = 24'h123456;
    #5 chk("reset_rx", {rx_lft, rx_rht}, 48'd0);
    chk("reset_ctl", {44'd0, SDout, tx_ack, rx_vld, frm_err}, 48'd0);
    #95 RST_n = 1'b1;
    for (int i = 0; i < 10; i++) bitp(1'b1, 30, 24'd0, dmy, 1'b0);
    frame(24'h7FFFFF, 24'h800000, {24'h7FFFFF, 24'h800000}, 32, -1, dec, txw);
    for (int n = 0; n < 5; n++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      frame(a, b, {a, b}, 32, -1, dec, txw);
    end
    for (int n = 0; n < 3; n++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      frame(a, b, {a, b}, n == 0 ? 30 : 32, -1, dec, txw);
    end
    for (int n = 0; n < 3; n++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      frame(a, b, {a, b}, 32, n == 0 ? 10 : -1, dec, txw);
    end
    ramp = 1'b1;
    a = 24'($urandom);
    b = 24'($urandom);
    frame(a, b, {a, b}, 32, -1, dec, txw);
    for (int n = 0; n < 16; n++) begin
      prev = txw;
      frame(dec[47:24], dec[23:0], prev, 32, -1, dec, txw);
    end
    repeat (20) @(negedge clk);
    chk("rx_pending", 48'(rx_q.size()), 48'd0);
    chk("ack_count", 48'(acks), 48'(nfrm));
    chk("err_count", 48'(errs), 48'(exp_err));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
